// File: rtl/temp_pkg.sv
// Shared types and sign-magnitude / two's-complement helpers for the
// multi-channel temperature supervisor.
package temp_pkg;

  localparam int TEMP_W_DEF = 21;
  localparam int MAG_MAX_W  = 32;

  typedef enum logic [1:0] {
    NORM = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } alarm_state_t;

  typedef logic signed [MAG_MAX_W:0] tc_t;

  // Negative zero folds to zero because -0 == 0 in two's complement.
  function automatic tc_t sm_to_tc(input logic sign, input logic [MAG_MAX_W-1:0] mag);
    return sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  function automatic logic [MAG_MAX_W-1:0] tc_to_mag(input tc_t v);
    return MAG_MAX_W'(v[MAG_MAX_W] ? -v : v);
  endfunction

endpackage

// File: rtl/temp_ch_track.sv
// Per-channel tracker: sample capture, running min/max, hysteretic
// high/low alarm and stale-sensor fault.
module temp_ch_track
  import temp_pkg::*;
#(
  parameter int TEMP_W    = TEMP_W_DEF,
  parameter int HYST      = 5000,
  parameter int STALE_CYC = 100_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_sign,
  input  logic [TEMP_W-1:0] din,
  input  logic              din_vld,
  input  logic [TEMP_W:0]   th_hi,
  input  logic [TEMP_W:0]   th_lo,
  input  logic              clr_minmax,
  output logic [TEMP_W:0]   cur,
  output logic [TEMP_W:0]   cur_min,
  output logic [TEMP_W:0]   cur_max,
  output logic              seen,
  output logic              alarm_hi,
  output logic              alarm_lo,
  output logic              fault
);

  localparam int SW = $clog2(STALE_CYC + 1);
  localparam logic signed [TEMP_W+1:0] HYST_X = (TEMP_W+2)'(HYST);

  logic signed [TEMP_W:0]   s;
  logic signed [TEMP_W+1:0] s_x, hi_x, lo_x;
  logic                     enter_hi, enter_lo, exit_hi, exit_lo;
  logic                     mm_valid;
  logic [SW-1:0]            stale_cnt;
  alarm_state_t             state, state_nxt;

  // One extra bit keeps threshold +/- hysteresis free of overflow.
  always_comb begin
    s        = (TEMP_W+1)'(sm_to_tc(din_sign, MAG_MAX_W'(din)));
    s_x      = (TEMP_W+2)'(s);
    hi_x     = (TEMP_W+2)'($signed(th_hi));
    lo_x     = (TEMP_W+2)'($signed(th_lo));
    enter_hi = s_x >= hi_x;
    enter_lo = s_x <= lo_x;
    exit_hi  = s_x < hi_x - HYST_X;
    exit_lo  = s_x > lo_x + HYST_X;
  end

  always_comb begin
    state_nxt = state;
    if (din_vld) begin
      case (state)
        NORM: begin
          if (enter_hi)      state_nxt = HIGH;
          else if (enter_lo) state_nxt = LOW;
        end
        HIGH: begin
          if (!enter_hi) begin
            if (enter_lo)     state_nxt = LOW;
            else if (exit_hi) state_nxt = NORM;
          end
        end
        LOW: begin
          if (enter_hi)     state_nxt = HIGH;
          else if (exit_lo) state_nxt = NORM;
        end
        default: state_nxt = NORM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NORM;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= '0;
      cur_min   <= '0;
      cur_max   <= '0;
      seen      <= 1'b0;
      mm_valid  <= 1'b0;
      stale_cnt <= '0;
    end else if (din_vld) begin
      cur       <= s;
      seen      <= 1'b1;
      mm_valid  <= 1'b1;
      stale_cnt <= '0;
      if (clr_minmax || !mm_valid) begin
        cur_min <= s;
        cur_max <= s;
      end else begin
        if (s < $signed(cur_min)) cur_min <= s;
        if (s > $signed(cur_max)) cur_max <= s;
      end
    end else begin
      if (clr_minmax) begin
        mm_valid <= 1'b0;
        cur_min  <= '0;
        cur_max  <= '0;
      end
      if (stale_cnt != SW'(STALE_CYC)) stale_cnt <= stale_cnt + 1'b1;
    end
  end

  assign alarm_hi = (state == HIGH);
  assign alarm_lo = (state == LOW);
  assign fault    = (stale_cnt == SW'(STALE_CYC));

endmodule

// File: rtl/temp_monitor_mc.sv
// Multi-channel temperature supervisor: per-channel trackers plus a
// round-robin display scanner emitting sign-magnitude data.
module temp_monitor_mc
  import temp_pkg::*;
#(
  parameter int CH_NUM    = 4,
  parameter int TEMP_W    = TEMP_W_DEF,
  parameter int HYST      = 5000,
  parameter int DWELL_CYC = 50_000_000,
  parameter int STALE_CYC = 100_000_000,
  localparam int CHW      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_NUM-1:0]        din_sign,
  input  logic [CH_NUM*TEMP_W-1:0] din,
  input  logic [CH_NUM-1:0]        din_vld,
  input  logic [TEMP_W:0]          th_hi,
  input  logic [TEMP_W:0]          th_lo,
  input  logic                     clr_minmax,
  input  logic                     disp_hold,
  output logic [CHW-1:0]           disp_ch,
  output logic                     disp_sign,
  output logic [TEMP_W-1:0]        disp_dout,
  output logic                     disp_dout_vld,
  output logic [TEMP_W:0]          disp_min,
  output logic [TEMP_W:0]          disp_max,
  output logic [CH_NUM-1:0]        alarm_hi,
  output logic [CH_NUM-1:0]        alarm_lo,
  output logic [CH_NUM-1:0]        fault
);

  localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

  logic [TEMP_W:0]   cur  [CH_NUM];
  logic [TEMP_W:0]   cmin [CH_NUM];
  logic [TEMP_W:0]   cmax [CH_NUM];
  logic [CH_NUM-1:0] seen;
  logic [CH_NUM-1:0] samp_d;
  logic              sw_d, trig;
  logic [DW-1:0]     dwell;
  logic [TEMP_W:0]   sel_cur, sel_min, sel_max;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    temp_ch_track #(
      .TEMP_W   (TEMP_W),
      .HYST     (HYST),
      .STALE_CYC(STALE_CYC)
    ) u_trk (
      .clk       (clk),
      .rst_n     (rst_n),
      .din_sign  (din_sign[g]),
      .din       (din[g*TEMP_W +: TEMP_W]),
      .din_vld   (din_vld[g]),
      .th_hi     (th_hi),
      .th_lo     (th_lo),
      .clr_minmax(clr_minmax),
      .cur       (cur[g]),
      .cur_min   (cmin[g]),
      .cur_max   (cmax[g]),
      .seen      (seen[g]),
      .alarm_hi  (alarm_hi[g]),
      .alarm_lo  (alarm_lo[g]),
      .fault     (fault[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      disp_ch <= '0;
      sw_d    <= 1'b0;
      samp_d  <= '0;
    end else begin
      samp_d <= din_vld;
      sw_d   <= 1'b0;
      if (!disp_hold) begin
        if (dwell == DW'(DWELL_CYC - 1)) begin
          dwell   <= '0;
          disp_ch <= (disp_ch == CHW'(CH_NUM - 1)) ? '0 : disp_ch + 1'b1;
          sw_d    <= 1'b1;
        end else begin
          dwell <= dwell + 1'b1;
        end
      end
    end
  end

  // Triggers are judged against the channel now on display, so a sample on
  // the channel just left merges into the single switch pulse.
  always_comb begin
    trig    = sw_d | samp_d[disp_ch];
    sel_cur = seen[disp_ch] ? cur[disp_ch]  : '0;
    sel_min = seen[disp_ch] ? cmin[disp_ch] : '0;
    sel_max = seen[disp_ch] ? cmax[disp_ch] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_sign     <= 1'b0;
      disp_dout     <= '0;
      disp_min      <= '0;
      disp_max      <= '0;
      disp_dout_vld <= 1'b0;
    end else begin
      disp_dout_vld <= trig;
      if (trig) begin
        disp_sign <= sel_cur[TEMP_W];
        disp_dout <= TEMP_W'(tc_to_mag(tc_t'($signed(sel_cur))));
        disp_min  <= sel_min;
        disp_max  <= sel_max;
      end
    end
  end

endmodule

// File: tb/tb_temp_monitor_mc.sv
// Directed bench for temp_monitor_mc with a cycle-level behavioural model
// and hand-computed literal checks.
module tb_temp_monitor_mc;

  localparam int CH = 4;
  localparam int TW = 21;
  localparam int HY = 5000;
  localparam int DW = 8;
  localparam int ST = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH-1:0]     din_sign = '0;
  logic [CH*TW-1:0]  din = '0;
  logic [CH-1:0]     din_vld = '0;
  logic [TW:0]       th_hi, th_lo;
  logic              clr_minmax = 1'b0;
  logic              disp_hold = 1'b0;
  logic [1:0]        disp_ch;
  logic              disp_sign;
  logic [TW-1:0]     disp_dout;
  logic              disp_dout_vld;
  logic [TW:0]       disp_min, disp_max;
  logic [CH-1:0]     alarm_hi, alarm_lo, fault;

  int th_hi_i = 300000;
  int th_lo_i = -200000;
  assign th_hi = th_hi_i[TW:0];
  assign th_lo = th_lo_i[TW:0];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  temp_monitor_mc #(
    .CH_NUM   (CH),
    .TEMP_W   (TW),
    .HYST     (HY),
    .DWELL_CYC(DW),
    .STALE_CYC(ST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din_sign     (din_sign),
    .din          (din),
    .din_vld      (din_vld),
    .th_hi        (th_hi),
    .th_lo        (th_lo),
    .clr_minmax   (clr_minmax),
    .disp_hold    (disp_hold),
    .disp_ch      (disp_ch),
    .disp_sign    (disp_sign),
    .disp_dout    (disp_dout),
    .disp_dout_vld(disp_dout_vld),
    .disp_min     (disp_min),
    .disp_max     (disp_max),
    .alarm_hi     (alarm_hi),
    .alarm_lo     (alarm_lo),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state as visible in cycle m_cyc (edges since reset).
  int m_cyc = 0, m_dwell = 0, m_ch = 0, m_sw = -10;
  int m_cur[CH] = '{default: 0};
  int m_mn[CH] = '{default: 0};
  int m_mx[CH] = '{default: 0};
  bit m_mmv[CH] = '{default: 1'b0};
  bit m_hi[CH] = '{default: 1'b0};
  bit m_lo[CH] = '{default: 1'b0};
  int m_base[CH] = '{default: 0};
  int m_samp[CH] = '{default: -10};
  bit m_vld = 1'b0, m_sign = 1'b0;
  int m_dout = 0, m_dmin = 0, m_dmax = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int k, s, v, mag;
    bit trig;
    if (!rst_n) begin
      m_cyc = 0; m_dwell = 0; m_ch = 0; m_sw = -10;
      m_vld = 0; m_sign = 0; m_dout = 0; m_dmin = 0; m_dmax = 0;
      for (int i = 0; i < CH; i++) begin
        m_cur[i] = 0; m_mn[i] = 0; m_mx[i] = 0; m_mmv[i] = 0;
        m_hi[i] = 0; m_lo[i] = 0; m_base[i] = 0; m_samp[i] = -10;
      end
    end else begin
      k = m_cyc;
      trig = (m_sw == k) || (m_samp[m_ch] == k - 1);
      m_vld = trig;
      if (trig) begin
        v = m_cur[m_ch];
        m_sign = (v < 0);
        m_dout = (v < 0) ? -v : v;
        m_dmin = m_mn[m_ch];
        m_dmax = m_mx[m_ch];
      end
      if (!disp_hold) begin
        if (m_dwell == DW - 1) begin
          m_dwell = 0;
          m_ch = (m_ch + 1) % CH;
          m_sw = k + 1;
        end else begin
          m_dwell++;
        end
      end
      for (int i = 0; i < CH; i++) begin
        if (din_vld[i]) begin
          mag = int'(din[i*TW +: TW]);
          s = din_sign[i] ? -mag : mag;
          m_cur[i] = s;
          if (clr_minmax || !m_mmv[i]) begin
            m_mn[i] = s; m_mx[i] = s;
          end else begin
            if (s < m_mn[i]) m_mn[i] = s;
            if (s > m_mx[i]) m_mx[i] = s;
          end
          m_mmv[i] = 1;
          if (s >= th_hi_i) begin
            m_hi[i] = 1; m_lo[i] = 0;
          end else if (s <= th_lo_i) begin
            m_hi[i] = 0; m_lo[i] = 1;
          end else if (m_hi[i] && s < th_hi_i - HY) begin
            m_hi[i] = 0;
          end else if (m_lo[i] && s > th_lo_i + HY) begin
            m_lo[i] = 0;
          end
          m_samp[i] = k;
          m_base[i] = k + 1;
        end else if (clr_minmax) begin
          m_mmv[i] = 0; m_mn[i] = 0; m_mx[i] = 0;
        end
      end
      m_cyc = k + 1;
    end
  end

  always @(negedge clk) begin : compare
    logic [CH-1:0] eh, el, ef;
    if (chk_en) begin
      for (int i = 0; i < CH; i++) begin
        eh[i] = m_hi[i];
        el[i] = m_lo[i];
        ef[i] = (m_cyc - m_base[i]) >= ST;
      end
      chk("disp_ch", disp_ch, m_ch);
      chk("disp_dout_vld", disp_dout_vld, m_vld);
      chk("disp_sign", disp_sign, m_sign);
      chk("disp_dout", disp_dout, m_dout);
      chk("disp_min", $signed(disp_min), m_dmin);
      chk("disp_max", $signed(disp_max), m_dmax);
      chk("alarm_hi", alarm_hi, eh);
      chk("alarm_lo", alarm_lo, el);
      chk("fault", fault, ef);
    end
  end

  task automatic sample(input int ch, input bit sg, input int mag, input bit clr);
    din_sign[ch] = sg;
    din[ch*TW +: TW] = mag[TW-1:0];
    din_vld[ch] = 1'b1;
    clr_minmax = clr;
    @(negedge clk);
    din_vld = '0;
    clr_minmax = 1'b0;
  endtask

  task automatic wait_ch(input int c);
    int n = 0;
    while (disp_ch != c[1:0] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ch", disp_ch, c);
  endtask

  initial begin : drive
    int hv[4] = '{299999, 300000, 296000, 294999};
    bit he[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit found;
    int val;

    repeat (3) @(negedge clk);
    chk("rst_disp_ch", disp_ch, 0);
    chk("rst_vld", disp_dout_vld, 0);
    chk("rst_dout", disp_dout, 0);
    chk("rst_fault", fault, 0);
    chk("rst_alarm_hi", alarm_hi, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    repeat (19) @(negedge clk);
    chk("fault_before", fault, 4'h0);
    @(negedge clk);
    chk("fault_at_20", fault, 4'hF);
    sample(2, 1'b0, 1000, 1'b0);
    chk("fault_clear", fault, 4'b1011);

    sample(1, 1'b1, 125000, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (disp_dout_vld && disp_ch == 2'd1) found = 1'b1;
    end
    chk("ch1_shown", found, 1);
    chk("ch1_sign", disp_sign, 1);
    chk("ch1_dout", disp_dout, 125000);
    chk("ch1_min", $signed(disp_min), -125000);
    chk("ch1_max", $signed(disp_max), -125000);

    for (int i = 0; i < 4; i++) begin
      sample(0, 1'b0, hv[i], 1'b0);
      chk("alarm_hi_hyst", alarm_hi[0], he[i]);
    end

    th_lo_i = -50000;
    th_hi_i = 60000;
    sample(3, 1'b1, 50000, 1'b0);
    chk("ch3_lo", alarm_lo[3], 1);
    chk("ch3_lo_hi", alarm_hi[3], 0);
    sample(3, 1'b0, 80000, 1'b0);
    chk("ch3_hi", alarm_hi[3], 1);
    chk("ch3_hi_lo", alarm_lo[3], 0);

    wait_ch(2);
    disp_hold = 1'b1;
    sample(2, 1'b0, 100, 1'b1);
    sample(2, 1'b1, 200, 1'b0);
    sample(2, 1'b0, 300, 1'b0);
    @(negedge clk);
    chk("mm_vld", disp_dout_vld, 1);
    chk("mm_min", $signed(disp_min), -200);
    chk("mm_max", $signed(disp_max), 300);
    sample(2, 1'b0, 50, 1'b1);
    @(negedge clk);
    chk("clr_min", $signed(disp_min), 50);
    chk("clr_max", $signed(disp_max), 50);
    chk("clr_dout", disp_dout, 50);
    sample(2, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("negzero_sign", disp_sign, 0);
    chk("negzero_dout", disp_dout, 0);
    chk("negzero_min", $signed(disp_min), 0);
    repeat (3 * DW) @(negedge clk);
    chk("hold_ch", disp_ch, 2);
    disp_hold = 1'b0;

    for (int n = 0; n < 20; n++) begin
      val = n * 7919 - 60000;
      sample(n % CH, val < 0, (val < 0) ? -val : val, 1'b0);
    end

    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_disp_ch", disp_ch, 0);
    chk("arst_dout", disp_dout, 0);
    chk("arst_alarm_hi", alarm_hi, 0);
    chk("arst_alarm_lo", alarm_lo, 0);
    chk("arst_fault", fault, 0);
    chk("arst_min", disp_min, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/temp_monitor_mc.md
# temp_monitor_mc

Multi-channel temperature supervisor placed between N DS18B20 driver instances and the shared BCD/segment/LCD display path. Per channel it holds the latest reading, running min/max, a hysteretic high/low alarm, and a stale-sensor fault. It also scans channels round-robin for display, emitting sign-magnitude data in the same format the drivers produce, so the display path is unchanged.

## Interface
- CH_NUM, 4, number of sensor channels (1..16)
- TEMP_W, 21, magnitude width; LSB = 0.0001 °C
- HYST, 5000, alarm hysteresis in LSBs (0.5 °C)
- DWELL_CYC, 50_000_000, display cycles per channel
- STALE_CYC, 100_000_000, cycles without a sample before fault
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- din_sign  in  CH_NUM  per-channel sign (1 = negative)
- din  in  CH_NUM*TEMP_W  packed magnitudes, ch0 in LSBs
- din_vld  in  CH_NUM  per-channel one-cycle sample strobe
- th_hi  in  TEMP_W+1  high threshold, two's complement
- th_lo  in  TEMP_W+1  low threshold, two's complement
- clr_minmax  in  1  pulse; restarts min/max on all channels
- disp_hold  in  1  level; freezes the scan on the current channel
- disp_ch  out  $clog2(CH_NUM) (min 1)  displayed channel index
- disp_sign  out  1  displayed sign
- disp_dout  out  TEMP_W  displayed magnitude
- disp_dout_vld  out  1  one-cycle strobe on display update
- disp_min, disp_max  out  TEMP_W+1 each  signed min/max of disp_ch
- alarm_hi, alarm_lo, fault  out  CH_NUM each  per-channel status

## Operation
- Capture on din_vld[i]: s = din_sign ? −mag : mag, as signed TEMP_W+1; −0 becomes 0. Registered into cur[i]; seen[i] set.
- Min/max: the first sample after reset or clr_minmax loads min = max = s; later samples update min/max when they are strictly beyond. If clr_minmax and din_vld[i] coincide, the new sample is the first sample.
- Alarm FSM per channel, evaluated only on samples. States: NORM, HIGH, LOW.
  - NORM→HIGH if s ≥ th_hi.
  - HIGH→NORM if s < th_hi − HYST.
  - NORM→LOW if s ≤ th_lo.
  - LOW→NORM if s > th_lo + HYST.
  - HIGH↔LOW is taken directly when the opposite entry condition holds.
  - If both entry conditions hold (th_lo ≥ th_hi), HIGH wins.
  - Threshold compares use TEMP_W+2-bit arithmetic, so there is no overflow.
- Outputs: alarm_hi[i] = (state == HIGH); alarm_lo[i] = (state == LOW).
- Stale counter per channel:
  - Counts cycles since the last sample and saturates at STALE_CYC.
  - fault[i] = 1 while saturated.
  - A sample clears the counter and fault in the same registered update.
- Scan:
  - The dwell counter runs 0..DWELL_CYC−1; at the terminal count disp_ch increments, wrapping CH_NUM−1→0.
  - disp_hold = 1 freezes the counter.
  - Faulted channels are not skipped.
- Display update triggers:
  - a channel switch, or
  - a sample captured on the current disp_ch.
- On each trigger, the display output stage loads sign/magnitude of cur[disp_ch] plus disp_min/disp_max, and pulses disp_dout_vld.
- Unseen channels display 0, sign 0, min = max = 0.

## Timing
- Reset values: all outputs 0; FSMs NORM; counters 0; seen 0; disp_ch 0.
- din_vld[i] at cycle t → cur, min/max, alarm_*, fault update at t+1.
- If i == disp_ch, disp_* values and disp_dout_vld are valid at t+2.
- Dwell terminal at t → disp_ch changes at t+1 → disp_dout_vld at t+2.
- Sample on the old channel coinciding with a switch: the new channel is shown and only one vld pulse is issued.
- Fault asserts exactly STALE_CYC cycles after the last sample, or after reset.
- Reset asserted mid-operation clears everything asynchronously; the first vld is output ≥ 2 cycles after deassertion.

## Structure
- Package temp_pkg: alarm state encoding (NORM = 2'd0, HIGH = 2'd1, LOW = 2'd2), TEMP_W default, sign-magnitude↔two's-complement conversion functions.
- Sub-module temp_ch_track, one per channel via generate: capture, min/max, alarm FSM, stale counter.
- Top level: dwell counter, channel mux, display output stage.

## Test plan
- CH_NUM = 4, DWELL_CYC = 8: ch1 gets sign = 1, din = 125000 (−12.5 °C) → after disp_ch reaches 1, disp_sign = 1, disp_dout = 125000, disp_min = disp_max = −125000, one vld pulse.
- th_hi = 300000, HYST = 5000: samples 299999, 300000, 296000, 294999 → alarm_hi = 0, 1, 1, 0.
- th_lo = −50000: samples −50000 then 80000 with th_hi = 60000 → LOW, then direct to HIGH.
- Samples 100, −200, 300, then clr_minmax together with sample 50 → min/max go −200/300 → 50/50.
- STALE_CYC = 20, no samples → fault = 1 at cycle 20; a sample clears it next cycle; reset pulse mid-scan → all outputs 0, disp_ch = 0.
- disp_hold = 1 for 3×DWELL_CYC → disp_ch constant; samples on the held channel still pulse vld at t+2.
